// File: rtl/serial_phase_acc_ctrl.sv
// serial_phase_acc_ctrl: bit-serial phase accumulator controller.
// Adds phase_inc into a WIDTH-bit phase register one bit per clock, LSB first,
// using one external full adder. One accumulate runs per accepted sample tick.
// Optional build macro: OVERRUN_DETECT_EN adds a sticky 'overrun' output that
// flags ticks dropped because an accumulate was already in progress.
module serial_phase_acc_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             sync,
  input  logic [WIDTH-1:0] phase_inc,
  input  logic             fa_sum,
  input  logic             fa_c_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c_in,
  output logic [WIDTH-1:0] phase_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
`ifdef OVERRUN_DETECT_EN
  ,
  output logic             overrun
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] acc_sr;
  logic [WIDTH-1:0] inc_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             in_add;
  logic [WIDTH-1:0] sum_word;

  assign in_add   = (state == S_ADD);
  assign busy     = (state != S_IDLE);
  // The word formed once this cycle's sum bit is shifted in; on the last bit
  // this is the complete new phase.
  assign sum_word = {fa_sum, acc_sr[WIDTH-1:1]};

  // Adder operands come straight from the shift-register LSBs while adding,
  // and are held at zero otherwise so the adder sits quiet between samples.
  always_comb begin
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_c_in = 1'b0;
    if (in_add) begin
      fa_a    = acc_sr[0];
      fa_b    = inc_sr[0];
      fa_c_in = carry;
    end
  end

  // Sequencer: accept tick/sync in IDLE, shift one bit per clock in ADD,
  // commit the result and pulse done, then return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase     <= '0;
      acc_sr    <= '0;
      inc_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      phase_out <= '0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (tick) begin
            acc_sr <= sync ? '0 : phase;
            inc_sr <= phase_inc;
            carry  <= 1'b0;
            cnt    <= '0;
            state  <= S_ADD;
          end else if (sync) begin
            phase     <= '0;
            phase_out <= '0;
          end
        end
        S_ADD: begin
          acc_sr <= sum_word;
          inc_sr <= inc_sr >> 1;
          carry  <= fa_c_out;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            phase     <= sum_word;
            phase_out <= sum_word;
            wrap      <= fa_c_out;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef OVERRUN_DETECT_EN
  // Sticky flag: any tick arriving while an accumulate is in flight is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (tick && busy) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/serial_phase_acc_ctrl.md
Name: serial_phase_acc_ctrl

Overview:
Bit-serial phase-accumulator controller for the oscillator. It time-shares one external one-bit full adder to add a phase increment into a WIDTH-bit phase register, one bit per clock, LSB first. One accumulate runs per sample tick. It sits between the sample-rate strobe and the waveform lookup, and its phase wrap drives square/sync outputs.

Parameters:
WIDTH, 16, phase accumulator and increment width in bits (≥2)
CNT_W, 5, bit counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
tick  in  1  sample strobe; starts one accumulate when sampled in IDLE
sync  in  1  hard sync; zeroes phase when sampled in IDLE
phase_inc  in  WIDTH  phase increment, latched when tick is accepted
fa_sum  in  1  sum from external full adder
fa_c_out  in  1  carry-out from external full adder
fa_a  out  1  adder operand A = current phase bit (combinational from state)
fa_b  out  1  adder operand B = current increment bit
fa_c_in  out  1  adder carry-in = registered carry
phase_out  out  WIDTH  committed phase, updated once per accumulate
busy  out  1  high in ADD and DONE
done  out  1  one-cycle pulse when phase_out updates
wrap  out  1  carry out of MSB of the last accumulate, valid and held until next done

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on rst_n. Reset clears state to IDLE and clears phase, shift registers, carry, counter, phase_out, busy, done, wrap and overrun to 0.
- States: IDLE, ADD, DONE.
- IDLE, tick=1: acc_sr<=phase (or 0 if sync=1 same edge), inc_sr<=phase_inc, carry<=0, cnt<=0, go ADD.
- IDLE, sync=1, tick=0: phase<=0, phase_out<=0, stay IDLE. wrap is unchanged.
- ADD: fa_a=acc_sr[0], fa_b=inc_sr[0], fa_c_in=carry. Each edge: acc_sr<={fa_sum,acc_sr[WIDTH-1:1]}, inc_sr>>=1 (zero fill), carry<=fa_c_out, cnt++.
- ADD, on the edge where cnt==WIDTH-1: phase<=final sum word, phase_out<=same, wrap<=fa_c_out, done<=1, go DONE.
- DONE: one cycle. done=1, then done<=0, go IDLE.
- Outside ADD, fa_a/fa_b/fa_c_in are driven 0.
- Latency: with tick sampled at edge E0, ADD runs edges E1..EWIDTH. phase_out and wrap change at EWIDTH, done is high for the cycle after EWIDTH, and IDLE is re-entered at EWIDTH+1. Minimum tick period is WIDTH+2 cycles.
- Arithmetic is modulo 2^WIDTH. Carry out of the MSB is never added back.
- tick or sync asserted while busy is ignored. The in-flight accumulate is unaffected. phase_inc changes during ADD have no effect.
- rst_n low mid-ADD aborts the operation. The next tick starts from phase 0.

Optional Feature:
OVERRUN_DETECT_EN
- Defined: adds output overrun (1 bit). It sets sticky on any edge where tick=1 while busy=1, and clears only on reset. Test overrun as an observable output.
- Undefined: port absent. Dropped ticks are silent.

Test Plan:
- Reset, WIDTH=8: rst_n=0 → phase_out=0x00, busy=0, done=0, wrap=0, fa_*=0, state IDLE. Release rst_n → no change without tick.
- phase_inc=0x03, single tick → busy for 9 cycles, fa_c_in=0 on first ADD cycle, done pulse exactly 1 cycle at E8+, phase_out=0x03, wrap=0.
- Phase at 0xFE, phase_inc=0x03, tick → phase_out=0x01, wrap=1. Next accumulate with inc=0x01 → phase_out=0x02, wrap=0.
- Second tick 3 cycles after first (inc=0x10, from 0) → only one done, phase_out=0x10. With OVERRUN_DETECT_EN, overrun=1 and stays 1.
- Phase at 0x50, sync=1 and tick=1 same edge, inc=0x10 → phase_out=0x10. sync alone in IDLE → phase_out=0x00 next cycle.
- rst_n pulsed low at 4th ADD cycle (inc=0x07, phase 0x20) → immediate clear, no done. Then a tick with inc=0x07 → phase_out=0x07.
